// File: rtl/burst_to_axi_ar.sv
// rtl/burst_to_axi_ar.sv - splits detected bursts into 4 KiB-safe AXI AR requests with an outstanding cap
module burst_to_axi_ar #(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int BurstLenWidth     = 8,
    parameter int AxiLenWidth       = 8,
    parameter int MaxOutstanding    = 16,
    parameter int OutstandingWidth  = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
    input  logic                               burst_empty_n,
    output logic                               burst_read,
    output logic [AddrWidth-1:0]               m_axi_araddr,
    output logic [AxiLenWidth-1:0]             m_axi_arlen,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,
    input  logic                               rlast_pulse,
    output logic                               busy
);

    localparam int BeatsWidth     = BurstLenWidth + 1;
    localparam int PageBeatsWidth = 13 - DataWidthBytesLog;
    localparam int ChunkW1        = (BeatsWidth > AxiLenWidth + 1) ? BeatsWidth : AxiLenWidth + 1;
    localparam int ChunkWidth     = (ChunkW1 > PageBeatsWidth) ? ChunkW1 : PageBeatsWidth;
    localparam logic [AddrWidth-1:0] AlignMask =
        ~((AddrWidth'(1) << DataWidthBytesLog) - AddrWidth'(1));

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                    state_q, state_d;
    logic [AddrWidth-1:0]      cur_addr_q, cur_addr_d;
    logic [BeatsWidth-1:0]     beats_left_q, beats_left_d;
    logic [AddrWidth-1:0]      araddr_q, araddr_d;
    logic [AxiLenWidth-1:0]    arlen_q, arlen_d;
    logic                      arvalid_q, arvalid_d;
    logic [OutstandingWidth-1:0] outstanding_q, outstanding_d;

    logic [BurstLenWidth-1:0]  in_len;
    logic [AddrWidth-1:0]      in_addr;
    logic [12:0]               page_room_bytes;
    logic [ChunkWidth-1:0]     room_beats;
    logic [ChunkWidth-1:0]     max_beats;
    logic [ChunkWidth-1:0]     beats_ext;
    logic [ChunkWidth-1:0]     chunk;
    logic [AddrWidth-1:0]      chunk_bytes;
    logic                      ar_hs;
    logic                      rlast_dec;
    logic                      issue_ok;

    assign in_len  = burst_dout[BurstLenWidth+AddrWidth-1:AddrWidth];
    assign in_addr = burst_dout[AddrWidth-1:0];

    // Beats left before the next 4 KiB page; cur_addr is beat aligned so this is never 0.
    assign page_room_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    assign room_beats      = ChunkWidth'(page_room_bytes >> DataWidthBytesLog);
    assign max_beats       = ChunkWidth'(1) << AxiLenWidth;
    assign beats_ext       = ChunkWidth'(beats_left_q);

    always_comb begin
        chunk = beats_ext;
        if (max_beats < chunk) begin
            chunk = max_beats;
        end
        if (room_beats < chunk) begin
            chunk = room_beats;
        end
    end

    assign chunk_bytes = AddrWidth'(chunk) << DataWidthBytesLog;
    assign ar_hs       = arvalid_q & m_axi_arready;
    assign rlast_dec   = rlast_pulse & (outstanding_q != '0);
    assign issue_ok    = outstanding_q < OutstandingWidth'(MaxOutstanding);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        burst_read   = 1'b0;

        case (state_q)
            IDLE: begin
                burst_read = burst_empty_n & rst_n;
                if (burst_empty_n) begin
                    cur_addr_d   = in_addr & AlignMask;
                    beats_left_d = BeatsWidth'(in_len) + BeatsWidth'(1);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // A request already presented stays put until accepted.
                if (!arvalid_q && issue_ok) begin
                    araddr_d  = cur_addr_q;
                    arlen_d   = AxiLenWidth'(chunk - ChunkWidth'(1));
                    arvalid_d = 1'b1;
                end
                if (ar_hs) begin
                    arvalid_d    = 1'b0;
                    cur_addr_d   = cur_addr_q + chunk_bytes;
                    beats_left_d = beats_left_q - BeatsWidth'(chunk);
                    if (beats_ext == chunk) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !rlast_dec) begin
            outstanding_d = outstanding_q + OutstandingWidth'(1);
        end else if (!ar_hs && rlast_dec) begin
            outstanding_d = outstanding_q - OutstandingWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            beats_left_q  <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            beats_left_q  <= beats_left_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arvalid_q     <= arvalid_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign busy          = (state_q != IDLE) | (outstanding_q != '0);

endmodule
